// File: rtl/ppa_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
// Provides the (g,p) pair type, its prefix operator, clog2 and register placement.
package ppa_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // hi covers the more significant span, lo the adjacent less significant span
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic int ppa_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Spreads `stages` register banks evenly over `l` prefix levels
  function automatic bit ppa_reg_after(input int level, input int stages, input int l);
    return (((level + 1) * stages) / l) > ((level * stages) / l);
  endfunction

endpackage

// File: rtl/ppa_prefix_level.sv
// One Kogge-Stone level: combines each bit with the bit DIST below it, with an
// optional register bank that also retimes a pass-through sideband vector.
module ppa_prefix_level
  import ppa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIST  = 1,
  parameter bit REG   = 1'b0,
  parameter int SW    = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en,
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  input  logic [SW-1:0]    side_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out,
  output logic [SW-1:0]    side_out
);

  logic [WIDTH-1:0] g_d;
  logic [WIDTH-1:0] p_d;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi >= DIST) begin : g_cmb
      gp_t r;
      assign r = gp_combine(gp_t'({g_in[gi], p_in[gi]}),
                            gp_t'({g_in[gi-DIST], p_in[gi-DIST]}));
      assign g_d[gi] = r.g;
      assign p_d[gi] = r.p;
    end else begin : g_pass
      assign g_d[gi] = g_in[gi];
      assign p_d[gi] = p_in[gi];
    end
  end

  if (REG) begin : g_reg
    logic [WIDTH-1:0] g_q;
    logic [WIDTH-1:0] p_q;
    logic [SW-1:0]    side_q;

    always_ff @(posedge clk) begin
      if (srst) begin
        g_q    <= '0;
        p_q    <= '0;
        side_q <= '0;
      end else if (en) begin
        g_q    <= g_d;
        p_q    <= p_d;
        side_q <= side_in;
      end
    end

    assign g_out    = g_q;
    assign p_out    = p_q;
    assign side_out = side_q;
  end else begin : g_comb
    logic unused_ctl;
    assign unused_ctl = clk ^ srst ^ en;
    assign g_out    = g_d;
    assign p_out    = p_d;
    assign side_out = side_in;
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined WIDTH-bit Kogge-Stone adder/subtractor with valid/ready streaming.
// Optional feature macro PPA_OVF_FLAG_EN adds the signed-overflow output ovf_out.
module pipelined_prefix_adder
  import ppa_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef PPA_OVF_FLAG_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int L   = ppa_clog2(WIDTH);
  localparam int LAT = STAGES + 1;
  localparam int SW  = WIDTH + 1;  // {cin', original p}

  logic             adv;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH-1:0] p0_d, p0_q;
  logic [WIDTH-1:0] g0_d, g0_q;
  logic             cin_d, cin_q;
  logic [LAT-1:0]   vld_d, vld_q;

  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = vld_q[LAT-1];

  always_comb begin
    b_x   = b_in ^ {WIDTH{sub_in}};
    cin_d = sub_in | c_in;
    p0_d  = a_in ^ b_x;
    g0_d  = a_in & b_x;
    // Folding cin' into bit 0 makes the tree's G[i] the carry out of bit i
    g0_d[0] = g0_d[0] | (p0_d[0] & cin_d);
    vld_d = (vld_q << 1) | LAT'(in_valid);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      p0_q  <= '0;
      g0_q  <= '0;
      cin_q <= 1'b0;
      vld_q <= '0;
    end else if (adv) begin
      p0_q  <= p0_d;
      g0_q  <= g0_d;
      cin_q <= cin_d;
      vld_q <= vld_d;
    end
  end

  logic [WIDTH-1:0] g_lvl    [0:L];
  logic [WIDTH-1:0] p_lvl    [0:L];
  logic [SW-1:0]    side_lvl [0:L];

  assign g_lvl[0]    = g0_q;
  assign p_lvl[0]    = p0_q;
  assign side_lvl[0] = {cin_q, p0_q};

  for (genvar gi = 0; gi < L; gi++) begin : g_level
    ppa_prefix_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << gi),
      .REG   (ppa_reg_after(gi, STAGES, L)),
      .SW    (SW)
    ) u_level (
      .clk      (wb_clk_i),
      .srst     (wb_rst_i),
      .en       (adv),
      .g_in     (g_lvl[gi]),
      .p_in     (p_lvl[gi]),
      .side_in  (side_lvl[gi]),
      .g_out    (g_lvl[gi+1]),
      .p_out    (p_lvl[gi+1]),
      .side_out (side_lvl[gi+1])
    );
  end

  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] p_fin;
  logic             cin_fin;
  logic             unused_p;

  assign carry            = g_lvl[L];
  assign {cin_fin, p_fin} = side_lvl[L];
  assign unused_p         = ^p_lvl[L];

  assign sum   = p_fin ^ {carry[WIDTH-2:0], cin_fin};
  assign c_out = carry[WIDTH-1];

`ifdef PPA_OVF_FLAG_EN
  assign ovf_out = carry[WIDTH-1] ^ carry[WIDTH-2];
`endif

endmodule
